ula_seq: RTL and testbench

//  Sequential, parametrised ALU for the multicycle MIPS datapath. Executes all

---
 rtl/ula_seq.sv | 145 ++++++++++++++
 tb/tb_ula_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// ula_seq: multicycle MIPS ALU, single-cycle ops plus iterative MULT/DIV into HI/LO
module ula_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       OP,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    localparam logic [4:0] OP_BNE  = 5'b01000;
    localparam logic [4:0] OP_MTHI = 5'b10110;
    localparam logic [4:0] OP_MTLO = 5'b10111;

    state_t             state_q;
    logic [WIDTH-1:0]   result_q, hi_q, lo_q, acc_q, qr_q, b_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               zf_q, busy_q, done_q, dz_q, div0_q, mul_q, neg_q, rneg_q;

    logic [WIDTH-1:0]   alu_d, acc_d, qr_d, hi_d, lo_d, a_mag, b_mag;
    logic [WIDTH:0]     sum, rsh, diff;
    logic [2*WIDTH-1:0] prod, prodf;
    logic [SHAMT_W-1:0] sh;
    logic               zf_d, iter_op, sa, sb, ge;

    // Single-cycle ALU result and operand preparation for the iterative ops
    always_comb begin
        sh = in1[SHAMT_W-1:0];
        case (OP)
            5'b00000:         alu_d = in1 & in2;
            5'b00001:         alu_d = in1 | in2;
            5'b00010:         alu_d = in1 + in2;
            5'b00011:         alu_d = in2 << sh;
            5'b00100:         alu_d = in2 >> sh;
            5'b00101:         alu_d = $signed(in2) >>> sh;
            5'b00110, OP_BNE: alu_d = in1 - in2;
            5'b00111:         alu_d = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
            5'b01011:         alu_d = in1 ^ in2;
            5'b01100:         alu_d = ~(in1 | in2);
            5'b01111:         alu_d = {{(WIDTH-1){1'b0}}, in1 < in2};
            5'b10100:         alu_d = hi_q;
            5'b10101:         alu_d = lo_q;
            OP_MTHI, OP_MTLO: alu_d = result_q;
            default:          alu_d = '0;
        endcase
        zf_d    = (alu_d == '0) ^ (OP == OP_BNE);
        iter_op = OP[4:2] == 3'b100;
        sa      = ~OP[0] & in1[WIDTH-1];
        sb      = ~OP[0] & in2[WIDTH-1];
        a_mag   = sa ? -in1 : in1;
        b_mag   = sb ? -in2 : in2;
    end

    // One shift-add / restoring shift-subtract step and the final sign correction
    always_comb begin
        sum   = {1'b0, acc_q} + (qr_q[0] ? {1'b0, b_q} : '0);
        rsh   = {acc_q, qr_q[WIDTH-1]};
        diff  = rsh - {1'b0, b_q};
        ge    = ~diff[WIDTH];
        acc_d = mul_q ? sum[WIDTH:1] : (ge ? diff[WIDTH-1:0] : rsh[WIDTH-1:0]);
        qr_d  = mul_q ? {sum[0], qr_q[WIDTH-1:1]} : {qr_q[WIDTH-2:0], ge};
        prod  = {acc_q, qr_q};
        prodf = neg_q ? -prod : prod;
        hi_d  = mul_q ? prodf[2*WIDTH-1:WIDTH] : (rneg_q ? -acc_q : acc_q);
        lo_d  = mul_q ? prodf[WIDTH-1:0] : (div0_q ? '1 : (neg_q ? -qr_q : qr_q));
    end

    // Control FSM: accepts requests in IDLE, iterates MULT/DIV, registers all outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            qr_q     <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            zf_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            div0_q   <= 1'b0;
            mul_q    <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && iter_op) begin
                        state_q <= ITER;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        qr_q    <= a_mag;
                        b_q     <= b_mag;
                        mul_q   <= ~OP[1];
                        neg_q   <= sa ^ sb;
                        rneg_q  <= sa;
                        div0_q  <= OP[1] & (in2 == '0);
                    end else if (start) begin
                        result_q <= alu_d;
                        zf_q     <= zf_d;
                        done_q   <= 1'b1;
                        if (OP == OP_MTHI) hi_q <= in1;
                        if (OP == OP_MTLO) lo_q <= in1;
                    end
                end
                ITER: begin
                    acc_q <= acc_d;
                    qr_q  <= qr_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    dz_q    <= div0_q;
                    zf_q    <= result_q == '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result      = result_q;
    assign zero_flag   = zf_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dz_q;
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed vectors with a scoreboard queue checked by a done-driven monitor
module tb_ula_seq;
    localparam int W = 32;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [4:0]   OP = '0;
    logic [W-1:0] in1 = '0, in2 = '0;
    logic [W-1:0] result;
    logic         zero_flag, busy, done, div_by_zero;

    typedef struct {
        logic [W-1:0] res;
        logic         zf;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    exp_t         e_mon;
    int           checks = 0, errors = 0;
    logic [W-1:0] last_res = '0;

    always #5 clk = ~clk;

    ula_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .OP(OP), .in1(in1), .in2(in2),
        .result(result), .zero_flag(zero_flag), .busy(busy), .done(done),
        .div_by_zero(div_by_zero)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) chk("unexpected_done", W'(done), W'(0));
            else begin
                e_mon = sb.pop_front();
                chk("result", result, e_mon.res);
                chk("zero_flag", W'(zero_flag), W'(e_mon.zf));
                chk("div_by_zero", W'(div_by_zero), W'(e_mon.dz));
            end
        end
        if (rst_n && div_by_zero && !done) chk("dz_without_done", W'(div_by_zero), W'(0));
    end

    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e, input int lat, input int nbusy, input bit poke);
        int n, bc;
        @(negedge clk);
        start = 1'b1; OP = op; in1 = a; in2 = b;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; OP = 5'b11111; in1 = $urandom; in2 = $urandom;
        n = 1;
        bc = int'(busy);
        while (!done && n < 200) begin
            if (poke && n == 5) begin
                start = 1'b1; OP = 5'b00010; in1 = 1; in2 = 2;
            end else start = 1'b0;
            @(posedge clk); #1;
            n++;
            bc += int'(busy);
        end
        start = 1'b0;
        chk($sformatf("latency op=%b", op), W'(n), W'(lat));
        chk($sformatf("busy_cycles op=%b", op), W'(bc), W'(nbusy));
    endtask

    task automatic alu(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er);
        exp_t e;
        e.res = er;
        e.zf  = (er == 0) ^ (op == 5'b01000);
        e.dz  = 1'b0;
        last_res = er;
        issue(op, a, b, e, 1, 0, 1'b0);
    endtask

    task automatic it(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic dz, input bit poke);
        exp_t e;
        e.res = last_res;
        e.zf  = last_res == 0;
        e.dz  = dz;
        issue(op, a, b, e, W + 2, W + 1, poke);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1;
        chk("reset_result", result, '0);
        chk("reset_zf", W'(zero_flag), W'(0));
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_done", W'(done), W'(0));
        chk("reset_dz", W'(div_by_zero), W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        alu(5'b00010, 5, 7, 12);
        alu(5'b01000, 3, 3, 0);
        alu(5'b01000, 3, 4, 32'hFFFFFFFF);
        alu(5'b00000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000);
        alu(5'b00001, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0);
        alu(5'b01011, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0);
        alu(5'b01100, 0, 0, 32'hFFFFFFFF);
        alu(5'b00110, 5, 7, 32'hFFFFFFFE);
        alu(5'b00110, 7, 7, 0);
        alu(5'b00010, 32'hFFFFFFFF, 1, 0);
        alu(5'b00011, 4, 1, 32'h00000010);
        alu(5'b00011, 31, 1, 32'h80000000);
        alu(5'b00100, 4, 32'h80000000, 32'h08000000);
        alu(5'b00101, 4, 32'h80000000, 32'hF8000000);
        alu(5'b00101, 32'h24, 32'h80000000, 32'hF8000000);
        alu(5'b00111, 32'hFFFFFFFF, 1, 1);
        alu(5'b01111, 32'hFFFFFFFF, 1, 0);
        alu(5'b00111, 1, 32'hFFFFFFFF, 0);
        alu(5'b01111, 1, 32'hFFFFFFFF, 1);
        alu(5'b01001, 5, 7, 0);
        alu(5'b11111, 5, 7, 0);

        it(5'b10000, 32'hFFFFFFFD, 4, 1'b0, 1'b1);
        alu(5'b10100, 0, 0, 32'hFFFFFFFF);
        alu(5'b10101, 0, 0, 32'hFFFFFFF4);
        it(5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        alu(5'b10100, 0, 0, 32'hFFFFFFFE);
        alu(5'b10101, 0, 0, 32'h00000001);
        it(5'b10000, 7, 32'hFFFFFFFA, 1'b0, 1'b0);
        alu(5'b10100, 0, 0, 32'hFFFFFFFF);
        alu(5'b10101, 0, 0, 32'hFFFFFFD6);
        it(5'b10011, 7, 0, 1'b1, 1'b0);
        alu(5'b10101, 0, 0, 32'hFFFFFFFF);
        alu(5'b10100, 0, 0, 7);
        it(5'b10010, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        alu(5'b10101, 0, 0, 32'h80000000);
        alu(5'b10100, 0, 0, 0);
        it(5'b10010, 32'hFFFFFFF9, 2, 1'b0, 1'b0);
        alu(5'b10101, 0, 0, 32'hFFFFFFFD);
        alu(5'b10100, 0, 0, 32'hFFFFFFFF);
        it(5'b10011, 100, 7, 1'b0, 1'b0);
        alu(5'b10101, 0, 0, 14);
        alu(5'b10100, 0, 0, 2);
        it(5'b10010, 7, 32'hFFFFFFFE, 1'b0, 1'b0);
        alu(5'b10101, 0, 0, 32'hFFFFFFFD);
        alu(5'b10100, 0, 0, 1);
        alu(5'b10110, 32'h0000ABCD, 0, last_res);
        alu(5'b10111, 32'h12345678, 0, last_res);
        alu(5'b10100, 0, 0, 32'h0000ABCD);
        alu(5'b10101, 0, 0, 32'h12345678);

        @(negedge clk);
        start = 1'b1; OP = 5'b10000; in1 = 3; in2 = 5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk("busy_before_reset", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        repeat (40) @(posedge clk);
        alu(5'b10100, 0, 0, 0);
        alu(5'b10101, 0, 0, 0);

        @(negedge clk); #1;
        chk("scoreboard_empty", W'(sb.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
